// File: rtl/zero_extend_8b_16b_if.sv
// Operand bus for the zero-extension unit: load enable, the narrow field,
// and both the combinational and registered widened results.
interface zero_extend_8b_16b_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic             en;
    logic [IN_W-1:0]  in;
    logic [OUT_W-1:0] out;
    logic [OUT_W-1:0] out_r;

    // Decode side drives the field and enable and consumes the results.
    modport master (
        output en,
        output in,
        input  out,
        input  out_r
    );

    // Extension unit consumes the field and enable and drives the results.
    modport slave (
        input  en,
        input  in,
        output out,
        output out_r
    );
endinterface

// File: rtl/zero_extend_8b_16b.sv
// Zero-extension unit: widens an IN_W-bit unsigned field to OUT_W bits by
// prepending zeros. `out` is combinational; `out_r` is a registered copy
// loaded on `en` and cleared by a synchronous active-high reset.
module zero_extend_8b_16b #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    zero_extend_8b_16b_if.slave   bus
);

    // Only the low IN_W bits are stored; the upper bits of out_r are
    // structurally tied to zero so they can never hold anything else.
    logic [IN_W-1:0] low_r;

    // Prepend zeros; the field's top bit is deliberately never replicated.
    function automatic logic [OUT_W-1:0] zext(input logic [IN_W-1:0] val);
        zext = {{(OUT_W - IN_W){1'b0}}, val};
    endfunction

    // Combinational widened value: tracks `in` with no clock or reset dependence.
    always_comb begin
        bus.out = zext(bus.in);
    end

    // Registered field capture: reset wins over enable, otherwise load or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_r <= {IN_W{1'b0}};
        end else if (bus.en) begin
            low_r <= bus.in;
        end else begin
            low_r <= low_r;
        end
    end

    // Registered widened value built from the stored field.
    always_comb begin
        bus.out_r = zext(low_r);
    end

endmodule

// File: tb/tb_zero_extend_8b_16b.sv
// Directed, table-driven bench for zero_extend_8b_16b.
module tb_zero_extend_8b_16b;

    logic clk;
    logic clk_on;
    logic reset;

    zero_extend_8b_16b_if #(.IN_W(8), .OUT_W(16)) bus ();

    zero_extend_8b_16b #(.IN_W(8), .OUT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Gated clock so the combinational checks can run with no edges at all.
    always begin
        #5;
        if (clk_on) clk = ~clk;
    end

    int n_cmp;
    int n_err;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  in;
        logic [15:0] exp_out;
        logic [15:0] exp_out_r;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check out before and after the edge, check out_r after.
    task automatic step(input string name, input logic r, input logic e, input logic [7:0] d,
                        input logic [15:0] exp_out, input logic [15:0] exp_out_r);
        reset  = r;
        bus.en = e;
        bus.in = d;
        #1;
        chk({name, ".out"}, bus.out, exp_out);
        @(posedge clk);
        #1;
        chk({name, ".out_r"}, bus.out_r, exp_out_r);
        chk({name, ".out_post"}, bus.out, exp_out);
    endtask

    logic [7:0]  sweep_in  [4];
    logic [15:0] sweep_exp [4];

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        clk    = 1'b0;
        clk_on = 1'b0;
        reset  = 1'b0;
        bus.en = 1'b0;
        bus.in = 8'h00;

        // Combinational path, no clock running.
        bus.in = 8'h0F;
        #100;
        chk("comb_0F", bus.out, 16'h000F);
        bus.in = 8'hF0;
        #5;
        chk("comb_F0_no_sign", bus.out, 16'h00F0);

        sweep_in[0] = 8'h00; sweep_exp[0] = 16'h0000;
        sweep_in[1] = 8'h7F; sweep_exp[1] = 16'h007F;
        sweep_in[2] = 8'h80; sweep_exp[2] = 16'h0080;
        sweep_in[3] = 8'hFF; sweep_exp[3] = 16'h00FF;
        for (int i = 0; i < 4; i++) begin
            bus.in = sweep_in[i];
            #2;
            chk($sformatf("sweep_%02h", sweep_in[i]), bus.out, sweep_exp[i]);
        end

        // Registered path vectors: {reset, en, in, expected out, expected out_r}.
        vecs[0] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 8'hA5, 16'h00A5, 16'h00A5};
        vecs[2] = '{1'b0, 1'b0, 8'h3C, 16'h003C, 16'h00A5};
        vecs[3] = '{1'b1, 1'b1, 8'h77, 16'h0077, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 8'h55, 16'h0055, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 8'hFF, 16'h00FF, 16'h00FF};
        vecs[6] = '{1'b0, 1'b1, 8'h80, 16'h0080, 16'h0080};
        vecs[7] = '{1'b1, 1'b0, 8'h12, 16'h0012, 16'h0000};
        vecs[8] = '{1'b0, 1'b1, 8'h01, 16'h0001, 16'h0001};
        vecs[9] = '{1'b0, 1'b1, 8'hF0, 16'h00F0, 16'h00F0};

        clk_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].in,
                 vecs[i].exp_out, vecs[i].exp_out_r);
        end

        // Multi-cycle hold: en low for several edges while in keeps changing.
        step("hold_a", 1'b0, 1'b0, 8'h11, 16'h0011, 16'h00F0);
        step("hold_b", 1'b0, 1'b0, 8'h22, 16'h0022, 16'h00F0);
        step("hold_c", 1'b0, 1'b0, 8'hEE, 16'h00EE, 16'h00F0);

        // Reset held over several edges, then loading resumes on the first en edge.
        step("rst_a",  1'b1, 1'b1, 8'h99, 16'h0099, 16'h0000);
        step("rst_b",  1'b1, 1'b1, 8'h9A, 16'h009A, 16'h0000);
        step("resume", 1'b0, 1'b1, 8'hC3, 16'h00C3, 16'h00C3);
        step("reload", 1'b0, 1'b1, 8'h7E, 16'h007E, 16'h007E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
